// File: rtl/multdiv_pkg.sv
// Shared definitions for the multdiv sequencer: FSM state encoding,
// operation codes, the $rstatus register index and default exception codes.
package multdiv_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    typedef enum logic {
        OP_MULT = 1'b0,
        OP_DIV  = 1'b1
    } op_t;

    localparam logic [4:0] RSTATUS_REG           = 5'd30;
    localparam int         MULT_EXC_CODE_DEFAULT = 4;
    localparam int         DIV_EXC_CODE_DEFAULT  = 5;

    // Exception code reported on wb_data for a given operation.
    function automatic int exc_code(input logic op, input int mult_code, input int div_code);
        return (op == OP_DIV) ? div_code : mult_code;
    endfunction

endpackage

// File: rtl/multdiv_cycle_counter.sv
// Busy-cycle counter for the multdiv sequencer. Cleared when a request is
// accepted, advanced once per RUN cycle, and flags the last allowed cycle
// (count == MAX_CYCLES-1) so the FSM can force a timeout completion.
module multdiv_cycle_counter #(
    parameter int MAX_CYCLES = 40,
    localparam int CW = (MAX_CYCLES > 1) ? $clog2(MAX_CYCLES) : 1
) (
    input  logic i_clock,
    input  logic i_reset,
    input  logic i_clear,
    input  logic i_enable,
    output logic o_tc
);

    logic [CW-1:0] r_count;

    // Count register: clear has priority over enable.
    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            r_count <= '0;
        end else if (i_clear) begin
            r_count <= '0;
        end else if (i_enable) begin
            r_count <= r_count + 1'b1;
        end
    end

    assign o_tc = (r_count == CW'(MAX_CYCLES - 1));

endmodule

// File: rtl/multdiv_ctrl.sv
// Sequencer between the execute stage and the iterative multdiv unit.
// Accepts one mult/div request, issues a single start pulse, holds operands,
// stalls the pipeline until the unit answers (or times out) and presents the
// result or $rstatus exception code for one cycle.
// Optional feature macro: MULTDIV_DIVZERO_FAST_EN -- divide by zero completes
// directly with the div exception code and never starts the unit.
module multdiv_ctrl
    import multdiv_pkg::*;
#(
    parameter int DW            = 32,
    parameter int MAX_CYCLES    = 40,
    parameter int MULT_EXC_CODE = MULT_EXC_CODE_DEFAULT,
    parameter int DIV_EXC_CODE  = DIV_EXC_CODE_DEFAULT
) (
    input  logic          i_clock,
    input  logic          i_reset,
    input  logic          i_req_valid,
    input  logic          i_req_op,
    input  logic [DW-1:0] i_req_a,
    input  logic [DW-1:0] i_req_b,
    input  logic [4:0]    i_req_rd,
    input  logic          i_flush,
    output logic          o_ctrl_MULT,
    output logic          o_ctrl_DIV,
    output logic [DW-1:0] o_unit_a,
    output logic [DW-1:0] o_unit_b,
    input  logic [DW-1:0] i_unit_result,
    input  logic          i_unit_exc,
    input  logic          i_unit_rdy,
    output logic          o_stall,
    output logic          o_wb_valid,
    output logic [DW-1:0] o_wb_data,
    output logic [4:0]    o_wb_reg,
    output logic          o_busy
);

    state_t        r_state;
    state_t        w_state_next;

    logic          r_op;
    logic [4:0]    r_rd;
    logic [DW-1:0] r_unit_a;
    logic [DW-1:0] r_unit_b;
    logic [DW-1:0] r_wb_data;
    logic [4:0]    r_wb_reg;

    logic          w_accept;
    logic          w_divzero;
    logic          w_launch;
    logic          w_stall;
    logic          w_cnt_clear;
    logic          w_cnt_en;
    logic          w_tc;
    logic          w_capture;
    logic [DW-1:0] w_cap_data;
    logic [4:0]    w_cap_reg;

    // A request is taken only from IDLE and never while reset is held, so
    // the combinational start pulse and stall are quiet during reset.
    assign w_accept = (r_state == IDLE) && i_req_valid && !i_flush && !i_reset;

`ifdef MULTDIV_DIVZERO_FAST_EN
    assign w_divzero = (i_req_op == OP_DIV) && (i_req_b == '0);
`else
    assign w_divzero = 1'b0;
`endif

    // The unit is only started when the request actually needs it.
    assign w_launch = w_accept && !w_divzero;

    multdiv_cycle_counter #(
        .MAX_CYCLES (MAX_CYCLES)
    ) u_counter (
        .i_clock  (i_clock),
        .i_reset  (i_reset),
        .i_clear  (w_cnt_clear),
        .i_enable (w_cnt_en),
        .o_tc     (w_tc)
    );

    // State register.
    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state, stall, counter control and result-capture selection.
    always_comb begin
        w_state_next = r_state;
        w_stall      = 1'b0;
        w_cnt_clear  = 1'b0;
        w_cnt_en     = 1'b0;
        w_capture    = 1'b0;
        w_cap_data   = '0;
        w_cap_reg    = '0;
        case (r_state)
            IDLE: begin
                if (w_accept) begin
                    w_stall     = 1'b1;
                    w_cnt_clear = 1'b1;
                    if (w_divzero) begin
                        // Short-circuit: the answer is known without the unit.
                        w_capture    = 1'b1;
                        w_cap_data   = DW'(DIV_EXC_CODE);
                        w_cap_reg    = RSTATUS_REG;
                        w_state_next = DONE;
                    end else begin
                        w_state_next = RUN;
                    end
                end
            end
            RUN: begin
                w_stall  = 1'b1;
                w_cnt_en = 1'b1;
                if (i_flush) begin
                    // Squashed instruction: drop whatever the unit returns.
                    w_state_next = IDLE;
                end else if (i_unit_rdy) begin
                    // A ready strobe beats a coincident timeout.
                    w_capture    = 1'b1;
                    w_state_next = DONE;
                    if (i_unit_exc) begin
                        w_cap_data = DW'(exc_code(r_op, MULT_EXC_CODE, DIV_EXC_CODE));
                        w_cap_reg  = RSTATUS_REG;
                    end else begin
                        w_cap_data = i_unit_result;
                        w_cap_reg  = r_rd;
                    end
                end else if (w_tc) begin
                    w_capture    = 1'b1;
                    w_cap_data   = DW'(exc_code(r_op, MULT_EXC_CODE, DIV_EXC_CODE));
                    w_cap_reg    = RSTATUS_REG;
                    w_state_next = DONE;
                end
            end
            DONE: begin
                // Same instruction is still presented here; do not re-accept it.
                w_state_next = IDLE;
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

    // Request latches: operands held stable for the unit while it runs.
    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            r_op     <= 1'b0;
            r_rd     <= '0;
            r_unit_a <= '0;
            r_unit_b <= '0;
        end else if (w_accept) begin
            r_op     <= i_req_op;
            r_rd     <= i_req_rd;
            r_unit_a <= i_req_a;
            r_unit_b <= i_req_b;
        end
    end

    // Write-back registers loaded on completion, shown during DONE.
    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            r_wb_data <= '0;
            r_wb_reg  <= '0;
        end else if (w_capture) begin
            r_wb_data <= w_cap_data;
            r_wb_reg  <= w_cap_reg;
        end
    end

    assign o_ctrl_MULT = w_launch && (i_req_op == OP_MULT);
    assign o_ctrl_DIV  = w_launch && (i_req_op == OP_DIV);
    assign o_unit_a    = r_unit_a;
    assign o_unit_b    = r_unit_b;
    assign o_stall     = w_stall;
    assign o_wb_valid  = (r_state == DONE);
    assign o_wb_data   = r_wb_data;
    assign o_wb_reg    = r_wb_reg;
    assign o_busy      = (r_state != IDLE);

endmodule
